// File: rtl/exp6_entrada_jogada.sv
// Player input stage: synchronizes and debounces the raw buttons, emits one jogada pulse per clean
// single-button press, and runs the timeout counter. Optional debug outputs under EXP6_ENTRADA_DEBUG_EN.
module exp6_entrada_jogada #(
    parameter int NBOTOES         = 4,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TIMEOUT_CICLOS  = 5000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NBOTOES-1:0]                botoes,
    input  logic                              contaT,
    output logic                              jogada,
    output logic [NBOTOES-1:0]                botoes_reg,
    output logic                              timeout,
    output logic                              db_tem_jogada
`ifdef EXP6_ENTRADA_DEBUG_EN
    ,
    output logic [1:0]                        db_estado_entrada,
    output logic [$clog2(TIMEOUT_CICLOS)-1:0] db_contagem_T
`endif
);

    localparam int DB_W = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int TW   = $clog2(TIMEOUT_CICLOS);
    localparam logic [DB_W-1:0] DB_ULTIMO = DB_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [TW-1:0]   T_ULTIMO  = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [1:0] {
        SOLTO    = 2'd0,
        PULSO    = 2'd1,
        AGUARDA  = 2'd2,
        INVALIDO = 2'd3
    } estado_t;

    logic [NBOTOES-1:0] sync1, sync2, estavel;
    logic [DB_W-1:0]    cnt_db;
    logic [TW-1:0]      cnt_t;
    estado_t            estado, estado_prox;
    logic               carrega;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= botoes;
            sync2 <= sync1;
        end
    end

    // sync1 is the value sync2 takes next: a mismatch restarts the stability count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estavel <= '0;
            cnt_db  <= '0;
        end else if (sync2 == estavel || sync2 != sync1) begin
            cnt_db <= '0;
        end else if (cnt_db == DB_ULTIMO) begin
            estavel <= sync2;
            cnt_db  <= '0;
        end else begin
            cnt_db <= cnt_db + DB_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= SOLTO;
            botoes_reg <= '0;
        end else begin
            estado <= estado_prox;
            if (carrega) begin
                botoes_reg <= estavel;
            end
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        estado_prox = estado;
        carrega     = 1'b0;
        case (estado)
            SOLTO: begin
                if (estavel == '0) begin
                    estado_prox = SOLTO;
                end else if ($onehot(estavel)) begin
                    estado_prox = PULSO;
                    carrega     = 1'b1;
                end else begin
                    estado_prox = INVALIDO;
                end
            end
            PULSO:    estado_prox = AGUARDA;
            AGUARDA:  if (estavel == '0) estado_prox = SOLTO;
            INVALIDO: if (estavel == '0) estado_prox = SOLTO;
            default:  estado_prox = SOLTO;
        endcase
    end

    assign jogada        = (estado == PULSO);
    assign db_tem_jogada = |estavel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_t <= '0;
        end else if (!contaT) begin
            cnt_t <= '0;
        end else if (cnt_t != T_ULTIMO) begin
            cnt_t <= cnt_t + TW'(1);
        end
    end

    assign timeout = contaT && (cnt_t == T_ULTIMO);

`ifdef EXP6_ENTRADA_DEBUG_EN
    assign db_estado_entrada = estado;
    assign db_contagem_T     = cnt_t;
`endif

endmodule

// File: tb/tb_exp6_entrada_jogada.sv
// Directed bench for exp6_entrada_jogada with DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=10.
module tb_exp6_entrada_jogada;

    localparam int NB = 4;
    localparam int TW = $clog2(10);

    logic          clock;
    logic          reset;
    logic [NB-1:0] botoes;
    logic          contaT;
    logic          jogada;
    logic [NB-1:0] botoes_reg;
    logic          timeout;
    logic          db_tem_jogada;
`ifdef EXP6_ENTRADA_DEBUG_EN
    logic [1:0]    db_estado_entrada;
    logic [TW-1:0] db_contagem_T;
`endif

    int total = 0;
    int bad   = 0;

    exp6_entrada_jogada #(
        .NBOTOES        (NB),
        .DEBOUNCE_CICLOS(4),
        .TIMEOUT_CICLOS (10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .botoes           (botoes),
        .contaT           (contaT),
        .jogada           (jogada),
        .botoes_reg       (botoes_reg),
        .timeout          (timeout),
        .db_tem_jogada    (db_tem_jogada)
`ifdef EXP6_ENTRADA_DEBUG_EN
        ,
        .db_estado_entrada(db_estado_entrada),
        .db_contagem_T    (db_contagem_T)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        botoes = '0;
        contaT = 1'b0;
        repeat (3) step();
        total++; if (jogada !== 1'b0) begin bad++; $display("FAIL rst_jogada got=%b exp=0", jogada); end
        total++; if (botoes_reg !== 4'b0000) begin bad++; $display("FAIL rst_botoes_reg got=%b exp=0000", botoes_reg); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        total++; if (db_tem_jogada !== 1'b0) begin bad++; $display("FAIL rst_db_tem_jogada got=%b exp=0", db_tem_jogada); end
        reset = 1'b0;
        step();
    endtask

    // Press 0100 for 20 cycles: pulse after the 7th edge, estavel visible after the 6th.
    task automatic test_press_basic();
        logic exp_j;
        botoes = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_j = (k == 7);
            total++; if (jogada !== exp_j) begin bad++; $display("FAIL t1_jogada k=%0d got=%b exp=%b", k, jogada, exp_j); end
            if (k == 5) begin
                total++; if (db_tem_jogada !== 1'b0) begin bad++; $display("FAIL t1_db_early got=%b exp=0", db_tem_jogada); end
            end
            if (k == 6) begin
                total++; if (db_tem_jogada !== 1'b1) begin bad++; $display("FAIL t1_db_set got=%b exp=1", db_tem_jogada); end
            end
            if (k == 8) begin
                total++; if (botoes_reg !== 4'b0100) begin bad++; $display("FAIL t1_botoes_reg got=%b exp=0100", botoes_reg); end
            end
        end
        botoes = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            step();
            total++; if (jogada !== 1'b0) begin bad++; $display("FAIL t1_rel_jogada k=%0d got=%b exp=0", k, jogada); end
            if (k == 5) begin
                total++; if (db_tem_jogada !== 1'b1) begin bad++; $display("FAIL t1_rel_db_hold got=%b exp=1", db_tem_jogada); end
            end
            if (k == 6) begin
                total++; if (db_tem_jogada !== 1'b0) begin bad++; $display("FAIL t1_rel_db_clear got=%b exp=0", db_tem_jogada); end
            end
        end
        total++; if (botoes_reg !== 4'b0100) begin bad++; $display("FAIL t1_held_reg got=%b exp=0100", botoes_reg); end
    endtask

    task automatic test_glitch();
        logic seen_j;
        logic seen_db;
        seen_j  = 1'b0;
        seen_db = 1'b0;
        botoes  = 4'b0001;
        repeat (3) step();
        botoes = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (jogada) seen_j = 1'b1;
            if (db_tem_jogada) seen_db = 1'b1;
        end
        total++; if (seen_j !== 1'b0) begin bad++; $display("FAIL t2_glitch_jogada got=%b exp=0", seen_j); end
        total++; if (seen_db !== 1'b0) begin bad++; $display("FAIL t2_glitch_estavel got=%b exp=0", seen_db); end
        total++; if (botoes_reg !== 4'b0100) begin bad++; $display("FAIL t2_botoes_reg got=%b exp=0100", botoes_reg); end
    endtask

    task automatic test_invalid();
        logic seen_j;
        int   pulses;
        int   first_k;
        seen_j = 1'b0;
        botoes = 4'b0011;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (jogada) seen_j = 1'b1;
            if (k == 6) begin
                total++; if (db_tem_jogada !== 1'b1) begin bad++; $display("FAIL t3_db_multi got=%b exp=1", db_tem_jogada); end
            end
        end
        total++; if (seen_j !== 1'b0) begin bad++; $display("FAIL t3_invalid_jogada got=%b exp=0", seen_j); end
        total++; if (botoes_reg !== 4'b0100) begin bad++; $display("FAIL t3_invalid_reg got=%b exp=0100", botoes_reg); end
`ifdef EXP6_ENTRADA_DEBUG_EN
        total++; if (db_estado_entrada !== 2'd3) begin bad++; $display("FAIL t3_state got=%0d exp=3", db_estado_entrada); end
`endif
        botoes = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (jogada) seen_j = 1'b1;
        end
        total++; if (seen_j !== 1'b0) begin bad++; $display("FAIL t3_release_jogada got=%b exp=0", seen_j); end
        total++; if (db_tem_jogada !== 1'b0) begin bad++; $display("FAIL t3_release_db got=%b exp=0", db_tem_jogada); end
        pulses  = 0;
        first_k = 0;
        botoes  = 4'b1000;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (jogada) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL t3_pulses got=%0d exp=1", pulses); end
        total++; if (first_k !== 7) begin bad++; $display("FAIL t3_pulse_cycle got=%0d exp=7", first_k); end
        total++; if (botoes_reg !== 4'b1000) begin bad++; $display("FAIL t3_reg got=%b exp=1000", botoes_reg); end
        botoes = 4'b0000;
        repeat (20) step();
    endtask

    task automatic test_timeout();
        logic exp_t;
        contaT = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_t = (k >= 9);
            total++; if (timeout !== exp_t) begin bad++; $display("FAIL t4_timeout k=%0d got=%b exp=%b", k, timeout, exp_t); end
        end
        contaT = 1'b0;
        #1;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL t4_drop got=%b exp=0", timeout); end
        step();
`ifdef EXP6_ENTRADA_DEBUG_EN
        total++; if (db_contagem_T !== '0) begin bad++; $display("FAIL t4_cnt_clear got=%0d exp=0", db_contagem_T); end
`endif
        contaT = 1'b1;
        #1;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL t4_cleared got=%b exp=0", timeout); end
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_t = (k >= 9);
            total++; if (timeout !== exp_t) begin bad++; $display("FAIL t4_restart k=%0d got=%b exp=%b", k, timeout, exp_t); end
        end
        contaT = 1'b0;
        step();
    endtask

    task automatic test_timeout_gap();
        logic seen_t;
        seen_t = 1'b0;
        contaT = 1'b1;
        for (int k = 1; k <= 5; k++) begin step(); if (timeout) seen_t = 1'b1; end
        contaT = 1'b0;
        step();
        if (timeout) seen_t = 1'b1;
        contaT = 1'b1;
        for (int k = 1; k <= 8; k++) begin step(); if (timeout) seen_t = 1'b1; end
        total++; if (seen_t !== 1'b0) begin bad++; $display("FAIL t5_gap_timeout got=%b exp=0", seen_t); end
        contaT = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_press();
        int pulses;
        int first_k;
        botoes = 4'b0010;
        contaT = 1'b1;
        repeat (12) step();
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL t6_pre_timeout got=%b exp=1", timeout); end
        total++; if (botoes_reg !== 4'b0010) begin bad++; $display("FAIL t6_pre_reg got=%b exp=0010", botoes_reg); end
        reset = 1'b1;
        #1;
        total++; if (jogada !== 1'b0) begin bad++; $display("FAIL t6_rst_jogada got=%b exp=0", jogada); end
        total++; if (botoes_reg !== 4'b0000) begin bad++; $display("FAIL t6_rst_reg got=%b exp=0000", botoes_reg); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL t6_rst_timeout got=%b exp=0", timeout); end
        total++; if (db_tem_jogada !== 1'b0) begin bad++; $display("FAIL t6_rst_db got=%b exp=0", db_tem_jogada); end
        contaT = 1'b0;
        repeat (2) step();
        reset   = 1'b0;
        pulses  = 0;
        first_k = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (jogada) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL t6_pulses got=%0d exp=1", pulses); end
        total++; if (first_k !== 7) begin bad++; $display("FAIL t6_pulse_cycle got=%0d exp=7", first_k); end
        total++; if (botoes_reg !== 4'b0010) begin bad++; $display("FAIL t6_reg got=%b exp=0010", botoes_reg); end
    endtask

    // Still in AGUARDA holding 0010: adding a second button must be ignored.
    task automatic test_aguarda_ignora();
        logic seen_j;
        seen_j = 1'b0;
        botoes = 4'b0110;
        for (int k = 1; k <= 12; k++) begin step(); if (jogada) seen_j = 1'b1; end
        botoes = 4'b0100;
        for (int k = 1; k <= 12; k++) begin step(); if (jogada) seen_j = 1'b1; end
        total++; if (seen_j !== 1'b0) begin bad++; $display("FAIL t7_aguarda_jogada got=%b exp=0", seen_j); end
        total++; if (botoes_reg !== 4'b0010) begin bad++; $display("FAIL t7_aguarda_reg got=%b exp=0010", botoes_reg); end
        botoes = 4'b0000;
        repeat (12) step();
    endtask

    initial begin
        test_reset();
        test_press_basic();
        test_glitch();
        test_invalid();
        test_timeout();
        test_timeout_gap();
        test_reset_mid_press();
        test_aguarda_ignora();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
